// File: rtl/mdio_master_ctrl.sv
// MDIO management master: Clause 22/45 frames, optional preamble, programmable MDC divider.
// All pad-facing outputs are registered; a frame is one pass through the FSM from IDLE.
module mdio_master_ctrl #(
    parameter int unsigned DIV_W   = 6,
    parameter int unsigned PRE_LEN = 32,
    parameter int unsigned DIV_RST = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             c45_i,
    input  logic [1:0]       op_i,
    input  logic [4:0]       phyad_i,
    input  logic [4:0]       regad_i,
    input  logic [15:0]      wdata_i,
    input  logic             pre_sup_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             abort_i,
    input  logic             md_i,
    output logic             md_o,
    output logic             mdoen_o,
    output logic             mdc_o,
    output logic [15:0]      rdata_o,
    output logic             done_o,
    output logic             ta_err_o
);

    typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StEnd} state_e;

    state_e             state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   hcnt_q, hcnt_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [31:0]        tx_q, tx_d;
    logic [15:0]        rx_q, rx_d;
    logic               rd_q, rd_d;
    logic               ta_bad_q, ta_bad_d;
    logic               mdc_q, mdc_d;
    logic               md_q, md_d;
    logic               oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               ta_err_q, ta_err_d;

    logic [DIV_W-1:0]   eff_half;
    logic [31:0]        tx_load;
    logic [31:0]        tx_shift;

    assign eff_half = (div_i == '0) ? DIV_W'(DIV_RST) : div_i;
    assign tx_load  = {c45_i ? 2'b00 : 2'b01, op_i, phyad_i, regad_i, 2'b10, wdata_i};
    assign tx_shift = {tx_q[30:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        hcnt_d    = hcnt_q;
        half_d    = half_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_d      = rd_q;
        ta_bad_d  = ta_bad_q;
        mdc_d     = mdc_q;
        md_d      = md_q;
        oe_d      = oe_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        ta_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    half_d   = eff_half;
                    hcnt_d   = eff_half - DIV_W'(1);
                    tx_d     = tx_load;
                    rd_d     = op_i[1];
                    ta_bad_d = 1'b0;
                    mdc_d    = 1'b0;
                    oe_d     = 1'b1;
                    ready_d  = 1'b0;
                    if (pre_sup_i) begin
                        state_d   = StHdr;
                        bit_cnt_d = 6'd13;
                        md_d      = tx_load[31];
                    end else begin
                        state_d   = StPre;
                        bit_cnt_d = 6'(PRE_LEN - 1);
                        md_d      = 1'b1;
                    end
                end
            end
            StEnd: begin
                state_d  = StIdle;
                done_d   = 1'b1;
                ready_d  = 1'b1;
                ta_err_d = rd_q & ta_bad_q;
                if (rd_q) begin
                    rdata_d = rx_q;
                end
            end
            default: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end else if (!mdc_q) begin
                    // Rising MDC: the PHY's bit is sampled here.
                    hcnt_d = half_q - DIV_W'(1);
                    mdc_d  = 1'b1;
                    if (state_q == StTa && bit_cnt_q == 6'd0) begin
                        ta_bad_d = md_i;
                    end
                    if (state_q == StData) begin
                        rx_d = {rx_q[14:0], md_i};
                    end
                end else begin
                    hcnt_d = half_q - DIV_W'(1);
                    mdc_d  = 1'b0;
                    if (state_q != StPre) begin
                        tx_d = tx_shift;
                    end
                    if (bit_cnt_q != 6'd0) begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        md_d      = (state_q == StPre) ? 1'b1
                                  : (rd_q && state_q != StHdr) ? 1'b1 : tx_shift[31];
                    end else begin
                        unique case (state_q)
                            StPre: begin
                                state_d   = StHdr;
                                bit_cnt_d = 6'd13;
                                md_d      = tx_q[31];
                            end
                            StHdr: begin
                                state_d   = StTa;
                                bit_cnt_d = 6'd1;
                                oe_d      = !rd_q;
                                md_d      = rd_q ? 1'b1 : tx_shift[31];
                            end
                            StTa: begin
                                state_d   = StData;
                                bit_cnt_d = 6'd15;
                                md_d      = rd_q ? 1'b1 : tx_shift[31];
                            end
                            default: begin
                                state_d = StEnd;
                                oe_d    = 1'b0;
                                md_d    = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Abort drops the frame without a completion; rdata_o is left untouched.
        if (abort_i && state_q != StIdle) begin
            state_d  = StIdle;
            mdc_d    = 1'b0;
            oe_d     = 1'b0;
            md_d     = 1'b1;
            ready_d  = 1'b1;
            done_d   = 1'b0;
            ta_err_d = 1'b0;
            rdata_d  = rdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            hcnt_q    <= '0;
            half_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_q      <= 1'b0;
            ta_bad_q  <= 1'b0;
            mdc_q     <= 1'b0;
            md_q      <= 1'b1;
            oe_q      <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            ta_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hcnt_q    <= hcnt_d;
            half_q    <= half_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            ta_bad_q  <= ta_bad_d;
            mdc_q     <= mdc_d;
            md_q      <= md_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            ta_err_q  <= ta_err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign md_o        = md_q;
    assign mdoen_o     = oe_q;
    assign mdc_o       = mdc_q;
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign ta_err_o    = ta_err_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Self-checking bench for mdio_master_ctrl: a frame-level model predicts every output per cycle.
module tb_mdio_master_ctrl;

    localparam int DIV_W   = 6;
    localparam int PRE_LEN = 32;
    localparam int DIV_RST = 10;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             c45_i = 1'b0;
    logic [1:0]       op_i = '0;
    logic [4:0]       phyad_i = '0;
    logic [4:0]       regad_i = '0;
    logic [15:0]      wdata_i = '0;
    logic             pre_sup_i = 1'b0;
    logic [DIV_W-1:0] div_i = '0;
    logic             abort_i = 1'b0;
    logic             md_i = 1'b1;
    logic             md_o;
    logic             mdoen_o;
    logic             mdc_o;
    logic [15:0]      rdata_o;
    logic             done_o;
    logic             ta_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_rdata = '0;

    mdio_master_ctrl #(.DIV_W(DIV_W), .PRE_LEN(PRE_LEN), .DIV_RST(DIV_RST)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .c45_i(c45_i), .op_i(op_i), .phyad_i(phyad_i), .regad_i(regad_i), .wdata_i(wdata_i),
        .pre_sup_i(pre_sup_i), .div_i(div_i), .abort_i(abort_i), .md_i(md_i), .md_o(md_o),
        .mdoen_o(mdoen_o), .mdc_o(mdc_o), .rdata_o(rdata_o), .done_o(done_o),
        .ta_err_o(ta_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits after the preamble, as they appear on the wire.
    function automatic logic [31:0] frame_word(input logic c45, input logic [1:0] op,
                                               input logic [4:0] phy, input logic [4:0] regad,
                                               input logic [15:0] wdata);
        return {c45 ? 2'b00 : 2'b01, op, phy, regad, 2'b10, wdata};
    endfunction

    task automatic run_frame(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [15:0] wdata,
                             input logic pre_sup, input logic [5:0] div, input int no_phy,
                             input logic [15:0] phy_data, input int abort_k, input int rst_k,
                             output int done_k);
        int h, p, n, b, j;
        logic rd;
        logic [31:0] word;
        logic e_ready, e_done, e_mdc, e_oe, e_md;
        logic [4:0] act, exp;
        done_k = -1;
        h    = (div == 0) ? DIV_RST : int'(div);
        p    = pre_sup ? 0 : PRE_LEN;
        n    = p + 32;
        rd   = op[1];
        word = frame_word(c45, op, phy, regad, wdata);

        @(negedge clk_i);
        c45_i = c45; op_i = op; phyad_i = phy; regad_i = regad; wdata_i = wdata;
        pre_sup_i = pre_sup; div_i = div; req_valid_i = 1'b1;
        check("ready_before_accept", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        // Scrambled inputs must be ignored for the rest of the frame.
        c45_i = 1'($urandom); op_i = 2'($urandom); phyad_i = 5'($urandom);
        regad_i = 5'($urandom); wdata_i = 16'($urandom); pre_sup_i = 1'($urandom);
        div_i = 6'($urandom_range(0, 6));

        for (int k = 0; k <= 2 * h * n + 3; k++) begin
            if (k > 0) begin
                @(posedge clk_i);
                #1;
            end
            e_md = 1'b1;
            if (k < 2 * h * n) begin
                b = k / (2 * h);
                j = b - p;
                e_ready = 0; e_done = 0;
                e_mdc = (k % (2 * h)) >= h;
                e_oe  = !(rd && j >= 14);
                e_md  = (b < p) ? 1'b1 : word[31 - j];
            end else begin
                e_ready = (k > 2 * h * n);
                e_done  = (k == 2 * h * n + 1);
                e_mdc = 0; e_oe = 0;
            end
            act = {req_ready_o, done_o, mdc_o, mdoen_o, e_oe ? md_o : 1'b0};
            exp = {e_ready, e_done, e_mdc, e_oe, e_oe ? e_md : 1'b0};
            check("pins", 32'(act), 32'(exp));
            if (e_done) begin
                done_k = k;
                if (rd) exp_rdata = no_phy ? 16'hFFFF : phy_data;
                check("ta_err", 32'(ta_err_o), 32'(rd && no_phy));
            end
            if (k > 2 * h * n) check("rdata", 32'(rdata_o), 32'(exp_rdata));
            if (k == abort_k) begin
                abort_i = 1'b1;
                @(posedge clk_i);
                #1;
                abort_i = 1'b0;
                check("abort_pins", 32'({req_ready_o, done_o, mdc_o, mdoen_o}), 32'b1000);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk_i);
                    #1;
                    check("abort_no_done", 32'({done_o, mdc_o}), 32'd0);
                end
                check("abort_rdata", 32'(rdata_o), 32'(exp_rdata));
                return;
            end
            if (k == rst_k) begin
                #1 rst_n_i = 1'b0;
                #1;
                exp_rdata = '0;
                check("reset_pins", 32'({req_ready_o, done_o, mdc_o, mdoen_o, md_o}), 32'b10001);
                check("reset_rdata", 32'({ta_err_o, rdata_o}), 32'd0);
                @(negedge clk_i);
                rst_n_i = 1'b1;
                return;
            end
            // PHY side: drive the bit that will be sampled during the next cycle.
            b = (k + 1) / (2 * h);
            j = b - p;
            if (!rd || j < 15 || no_phy != 0) md_i = 1'b1;
            else if (j == 15) md_i = 1'b0;
            else md_i = (j < 32) ? phy_data[31 - j] : 1'b1;
        end
    endtask

    initial begin
        int dk;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pins", 32'({req_ready_o, done_o, mdc_o, mdoen_o, md_o}), 32'b10001);
        check("rst_data", 32'({ta_err_o, rdata_o}), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_pins", 32'({req_ready_o, mdc_o, mdoen_o}), 32'b100);

        check("model_word", frame_word(1'b0, 2'b01, 5'd3, 5'd0, 16'h1140), 32'h5182_1140);

        run_frame(1'b0, 2'b01, 5'd3, 5'd0, 16'h1140, 1'b0, 6'd2, 0, 16'h0, -1, -1, dk);
        check("c22_wr_latency", 32'(dk), 32'd257);

        run_frame(1'b1, 2'b11, 5'd1, 5'd7, 16'h0, 1'b1, 6'd4, 0, 16'hABCD, -1, -1, dk);
        check("c45_rd_latency", 32'(dk), 32'd257);
        check("c45_rd_data", 32'({ta_err_o, rdata_o}), 32'h0ABCD);

        run_frame(1'b0, 2'b10, 5'd9, 5'd2, 16'h0, 1'b1, 6'd3, 1, 16'h0, -1, -1, dk);
        check("nophy_rdata", 32'(rdata_o), 32'hFFFF);

        run_frame(1'b0, 2'b01, 5'd5, 5'd4, 16'h5A5A, 1'b1, 6'd0, 0, 16'h0, -1, -1, dk);
        check("div0_latency", 32'(dk), 32'd641);
        run_frame(1'b1, 2'b10, 5'd2, 5'd1, 16'h0, 1'b0, 6'd1, 0, 16'h1234, -1, -1, dk);
        check("div1_latency", 32'(dk), 32'd129);
        check("div1_rdata", 32'(rdata_o), 32'h1234);

        run_frame(1'b0, 2'b01, 5'd3, 5'd3, 16'hBEEF, 1'b0, 6'd2, 0, 16'h0, 161, -1, dk);
        run_frame(1'b0, 2'b01, 5'd3, 5'd3, 16'hBEEF, 1'b0, 6'd2, 0, 16'h0, -1, -1, dk);
        check("post_abort_latency", 32'(dk), 32'd257);

        run_frame(1'b0, 2'b10, 5'd4, 5'd4, 16'h0, 1'b1, 6'd2, 0, 16'h7777, 70, -1, dk);
        run_frame(1'b0, 2'b10, 5'd4, 5'd4, 16'h0, 1'b1, 6'd2, 0, 16'h7777, -1, 90, dk);
        check("post_reset_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_frame(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                      1'($urandom), 6'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, 16'($urandom), -1, -1, dk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
